// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between two
// requesters (req 0 = integer pipe, req 1 = debug/CSR path). One operation is
// in flight at a time. The flow is IDLE (grant), then EXEC (ALU settles),
// then RESP (result held until it is consumed).
//
// Optional feature: define ALU_ARB_ZF_EN to add the resp_zf output. It is a
// zero flag, registered alongside resp_data.
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,

    output logic [N-1:0] alu_rs1,
    output logic [N-1:0] alu_rs2,
    output logic [3:0]   alu_ctrl,
    input  logic [N-1:0] alu_res,

    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [N-1:0] resp_data,
    output logic         resp_err
`ifdef ALU_ARB_ZF_EN
    ,
    output logic         resp_zf
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]   state;
    logic         prio;       // requester favoured when both are valid
    logic         cur_id;     // requester owning the in-flight operation

    logic         win_id;
    logic [3:0]   win_op;
    logic [N-1:0] win_a;
    logic [N-1:0] win_b;
    logic         accept;
    logic         op_legal;

    // Winner selection: a lone valid requester wins; on contention prio decides
    always_comb begin
        win_id = 1'b0;
        if (req0_valid && req1_valid) begin
            win_id = prio;
        end else if (req1_valid) begin
            win_id = 1'b1;
        end
    end

    // Operand mux for the selected requester
    always_comb begin
        win_op = req0_op;
        win_a  = req0_a;
        win_b  = req0_b;
        if (win_id) begin
            win_op = req1_op;
            win_a  = req1_a;
            win_b  = req1_b;
        end
    end

    // Ready only in IDLE, only for the winner, and never while reset is held
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && state == IDLE) begin
            req0_ready = req0_valid && !win_id;
            req1_ready = req1_valid &&  win_id;
        end
        accept = req0_ready || req1_ready;
    end

    // Decode of the legal ALU control codes
    always_comb begin
        case (alu_ctrl)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b0110, 4'b0111,
            4'b1000, 4'b1010: op_legal = 1'b1;
            default:          op_legal = 1'b0;
        endcase
    end

    // Control FSM: grant in IDLE, one EXEC cycle, hold response in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state <= EXEC;
                EXEC: state <= RESP;
                RESP: if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Round-robin pointer: favour the loser of the grant just completed
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (state == RESP && resp_valid && resp_ready) begin
            prio <= ~resp_id;
        end
    end

    // Registered ALU operands and owner ID, loaded on the accept edge only
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_rs1  <= '0;
            alu_rs2  <= '0;
            alu_ctrl <= '0;
            cur_id   <= 1'b0;
        end else if (state == IDLE && accept) begin
            alu_rs1  <= win_a;
            alu_rs2  <= win_b;
            alu_ctrl <= win_op;
            cur_id   <= win_id;
        end
    end

    // Response capture at the end of EXEC, held until consumed in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                EXEC: begin
                    resp_valid <= 1'b1;
                    resp_id    <= cur_id;
                    if (op_legal) begin
                        resp_data <= alu_res;
                        resp_err  <= 1'b0;
                    end else begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ARB_ZF_EN
    // Zero flag captured with resp_data; forced low for illegal ops
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_zf <= 1'b0;
        end else if (state == EXEC) begin
            resp_zf <= op_legal && (alu_res == '0);
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. A behavioural ALU model drives alu_res from
// the DUT's registered operands. All expected values are hand-computed
// constants.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [31:0] alu_rs1, alu_rs2, alu_res;
    logic [3:0]  alu_ctrl;
    logic        resp_valid, resp_ready, resp_id, resp_err;
    logic [31:0] resp_data;
`ifdef ALU_ARB_ZF_EN
    logic        resp_zf;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_rs1    (alu_rs1),
        .alu_rs2    (alu_rs2),
        .alu_ctrl   (alu_ctrl),
        .alu_res    (alu_res),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
`ifdef ALU_ARB_ZF_EN
        ,
        .resp_zf    (resp_zf)
`endif
    );

    // Behavioural ALU. Illegal codes return a nonzero value, so a leak into
    // resp_data is visible.
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_res = alu_rs1 & alu_rs2;
            4'b0001: alu_res = alu_rs1 | alu_rs2;
            4'b0010: alu_res = alu_rs1 + alu_rs2;
            4'b0110: alu_res = alu_rs1 - alu_rs2;
            4'b0111: alu_res = alu_rs1 ^ alu_rs2;
            4'b1010: alu_res = alu_rs1 << alu_rs2[4:0];
            default: alu_res = 32'hDEAD_BEEF ^ alu_rs1 ^ alu_rs2;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One uncontended operation. The task enters and leaves at an IDLE
    // negedge, and resp_ready must already be high.
    task automatic run_single(input logic id, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp, input logic err);
        if (id) begin
            req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_op = op; req0_a = a; req0_b = b;
        end
        req0_valid = !id;
        req1_valid = id;
        #1;
        chk("s_ready0", 32'(req0_ready), 32'(!id));
        chk("s_ready1", 32'(req1_ready), 32'(id));
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("s_ctrl", 32'(alu_ctrl), 32'(op));
        chk("s_rs1", alu_rs1, a);
        chk("s_rs2", alu_rs2, b);
        chk("s_exec_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("s_valid", 32'(resp_valid), 32'd1);
        chk("s_id", 32'(resp_id), 32'(id));
        chk("s_data", resp_data, exp);
        chk("s_err", 32'(resp_err), 32'(err));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = '0; req0_a = '0; req0_b = '0;
        req1_op = '0; req1_a = '0; req1_b = '0;
        resp_ready = 1'b0;

        // Reset state, including no grant while reset is held with both valid
        @(negedge clk);
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_rs1", alu_rs1, 32'd0);
        chk("rst_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_data", resp_data, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;

        // Single request: 5 + 7 = 12 from requester 0 (prio becomes 1)
        run_single(1'b0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0);

        // Reset asserted during EXEC aborts the operation and clears prio
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd1; req0_b = 32'd1;
        #1;
        chk("mid_ready0", 32'(req0_ready), 32'd1);
        @(negedge clk);
        chk("mid_rs1", alu_rs1, 32'd1);
        rst = 1'b1;
        req0_op = 4'b0110; req0_a = 32'd10;   req0_b = 32'd3;
        req1_op = 4'b0000; req1_a = 32'hF0;   req1_b = 32'h3C;
        req1_valid = 1'b1;
        @(negedge clk);
        chk("mid_valid", 32'(resp_valid), 32'd0);
        chk("mid_ready0", 32'(req0_ready), 32'd0);
        chk("mid_ready1", 32'(req1_ready), 32'd0);
        chk("mid_rs1_clr", alu_rs1, 32'd0);
        chk("mid_rs2_clr", alu_rs2, 32'd0);
        chk("mid_ctrl_clr", 32'(alu_ctrl), 32'd0);
        chk("mid_data_clr", resp_data, 32'd0);
        @(negedge clk);
        chk("mid_valid2", 32'(resp_valid), 32'd0);
        rst = 1'b0;

        // Contention: both valid every cycle, so grants alternate 0,1,0,1
        for (int unsigned i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready1", 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            @(negedge clk);
            chk("rr_exec_rdy0", 32'(req0_ready), 32'd0);
            chk("rr_exec_rdy1", 32'(req1_ready), 32'd0);
            @(negedge clk);
            chk("rr_valid", 32'(resp_valid), 32'd1);
            chk("rr_id", 32'(resp_id), (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("rr_data", resp_data, (i % 2 == 1) ? 32'h30 : 32'd7);
            @(negedge clk);
        end

        // Backpressure: response held for several cycles, with no grants meanwhile
        req0_valid = 1'b0;
        req1_op = 4'b0111; req1_a = 32'hFF; req1_b = 32'h0F;
        #1;
        chk("bp_ready1", 32'(req1_ready), 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        resp_ready = 1'b0;
        #1;
        chk("bp_exec_rdy0", 32'(req0_ready), 32'd0);
        @(negedge clk);
        chk("bp_valid", 32'(resp_valid), 32'd1);
        chk("bp_data", resp_data, 32'hF0);
        chk("bp_id", 32'(resp_id), 32'd1);
        req1_valid = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("bp_hold_valid", 32'(resp_valid), 32'd1);
            chk("bp_hold_data", resp_data, 32'hF0);
            chk("bp_hold_rdy0", 32'(req0_ready), 32'd0);
            chk("bp_hold_rdy1", 32'(req1_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_next_rdy0", 32'(req0_ready), 32'd1);
        chk("bp_next_rdy1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_data", resp_data, 32'd7);
        chk("bp_next_id", 32'(resp_id), 32'd0);
        @(negedge clk);

        // Illegal op, then legal ops afterwards clear resp_err
        run_single(1'b0, 4'b1111, 32'd1, 32'd1, 32'd0, 1'b1);
`ifdef ALU_ARB_ZF_EN
        chk("zf_illegal", 32'(resp_zf), 32'd0);
`endif
        run_single(1'b0, 4'b0010, 32'd1, 32'd0, 32'd1, 1'b0);
`ifdef ALU_ARB_ZF_EN
        chk("zf_nonzero", 32'(resp_zf), 32'd0);
`endif
        run_single(1'b1, 4'b1010, 32'd3, 32'd2, 32'd12, 1'b0);
        run_single(1'b1, 4'b1001, 32'd1, 32'd1, 32'd0, 1'b1);
        run_single(1'b0, 4'b0110, 32'd9, 32'd9, 32'd0, 1'b0);
`ifdef ALU_ARB_ZF_EN
        chk("zf_zero", 32'(resp_zf), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
